// File: rtl/group_add.sv
// Pipelined signed adder tree: sums GROUP_NB addends per cycle with one register per tree level.
// Define GROUP_ADD_SATURATE_EN to clamp the final sum instead of wrapping it.
module group_add #(
    parameter int GROUP_NB  = 4,
    parameter int NUM_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
    output logic [NUM_WIDTH-1:0]          dn_data
);

    // A single addend still goes through one register so dn_data stays a pure flop output.
    localparam int L  = (GROUP_NB <= 1) ? 1 : $clog2(GROUP_NB);
    localparam int SW = NUM_WIDTH + L;

    // Number of operands present after k tree levels.
    function automatic int level_count(input int k);
        return (GROUP_NB + (1 << k) - 1) >> k;
    endfunction

    function automatic logic [NUM_WIDTH-1:0] finish_sum(input logic signed [SW-1:0] full);
`ifdef GROUP_ADD_SATURATE_EN
        logic signed [SW-1:0] max_v;
        logic signed [SW-1:0] min_v;
        max_v = {{(L+1){1'b0}}, {(NUM_WIDTH-1){1'b1}}};
        min_v = {{(L+1){1'b1}}, {(NUM_WIDTH-1){1'b0}}};
        if (full > max_v)
            return {1'b0, {(NUM_WIDTH-1){1'b1}}};
        else if (full < min_v)
            return {1'b1, {(NUM_WIDTH-1){1'b0}}};
        else
            return full[NUM_WIDTH-1:0];
`else
        return full[NUM_WIDTH-1:0];
`endif
    endfunction

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int N_IN  = level_count(k - 1);
        localparam int N_OUT = level_count(k);
        localparam int W_IN  = NUM_WIDTH + k - 1;
        localparam int W_OUT = W_IN + 1;
        localparam int QW    = (k < L) ? N_OUT * W_OUT : NUM_WIDTH;

        logic [N_IN*W_IN-1:0]   din;
        logic [N_OUT*W_OUT-1:0] sum;
        logic [QW-1:0]          q;

        if (k == 1) begin : g_src
            assign din = up_data;
        end else begin : g_src
            assign din = g_lvl[k-1].q;
        end

        // Pairs are added one bit wider; an odd leftover is only sign-extended and passed on.
        always_comb begin
            int hi;
            sum = '0;
            hi  = 0;
            for (int j = 0; j < N_OUT; j++) begin
                hi = (2*j + 1 < N_IN) ? 2*j + 1 : 2*j;
                sum[j*W_OUT +: W_OUT] = W_OUT'(signed'(din[2*j*W_IN +: W_IN]));
                if (hi != 2*j)
                    sum[j*W_OUT +: W_OUT] = sum[j*W_OUT +: W_OUT]
                                          + W_OUT'(signed'(din[hi*W_IN +: W_IN]));
            end
        end

        if (k < L) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else
                    q <= sum;
            end
        end else begin : g_out
            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else
                    q <= finish_sum(sum);
            end
        end
    end

    assign dn_data = g_lvl[L].q;

endmodule

// File: tb/tb_group_add.sv
// Directed and random checks of group_add for group sizes 4, 3 and 1 with 16-bit Q8.8 addends.
module tb_group_add;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] up4;
    logic [47:0] up3;
    logic [15:0] up1;
    logic [15:0] dn4;
    logic [15:0] dn3;
    logic [15:0] dn1;

    logic [15:0] exp_q4[$];
    logic [15:0] exp_q3[$];
    logic [15:0] exp_q1[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    group_add #(.GROUP_NB(4), .NUM_WIDTH(16)) dut4 (
        .clk(clk), .rst(rst), .up_data(up4), .dn_data(dn4)
    );
    group_add #(.GROUP_NB(3), .NUM_WIDTH(16)) dut3 (
        .clk(clk), .rst(rst), .up_data(up3), .dn_data(dn3)
    );
    group_add #(.GROUP_NB(1), .NUM_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .up_data(up1), .dn_data(dn1)
    );

    // Reference sum over the first n elements, wide accumulation then wrap or clamp.
    function automatic logic [15:0] model(input logic [63:0] d, input int n);
        int acc;
        acc = 0;
        for (int i = 0; i < n; i++)
            acc += int'($signed(d[i*16 +: 16]));
`ifdef GROUP_ADD_SATURATE_EN
        if (acc > 32767)
            acc = 32767;
        else if (acc < -32768)
            acc = -32768;
`endif
        return acc[15:0];
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                          input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, push expectations, sample 1 time unit after the rising edge.
    task automatic step(input logic r,
                        input logic [63:0] d4, input logic [15:0] x4,
                        input logic [47:0] d3, input logic [15:0] x3,
                        input logic [15:0] d1, input logic [15:0] x1);
        logic [15:0] e4, e3, e1;
        @(negedge clk);
        rst = r;
        up4 = d4;
        up3 = d3;
        up1 = d1;
        if (!r) begin
            exp_q4.push_back(x4);
            exp_q3.push_back(x3);
            exp_q1.push_back(x1);
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_q4.delete();
            exp_q3.delete();
            exp_q1.delete();
            exp_q4.push_back(16'h0000);
            exp_q3.push_back(16'h0000);
            e4 = 16'h0000;
            e3 = 16'h0000;
            e1 = 16'h0000;
        end else begin
            e4 = exp_q4.pop_front();
            e3 = exp_q3.pop_front();
            e1 = exp_q1.pop_front();
        end
        check("dn4", dn4, e4);
        check("dn3", dn3, e3);
        check("dn1", dn1, e1);
    endtask

    // Directed value for the 4-wide DUT; the smaller DUTs see its low elements.
    task automatic step4(input logic r, input logic [63:0] d4, input logic [15:0] x4);
        step(r, d4, x4, d4[47:0], model(d4, 3), d4[15:0], model(d4, 1));
    endtask

    task automatic step_rand();
        logic [63:0] d;
        d = {$urandom(), $urandom()};
        step(1'b0, d, model(d, 4), d[47:0], model(d, 3), d[15:0], model(d, 1));
    endtask

    initial begin
        rst = 1'b1;
        up4 = '0;
        up3 = '0;
        up1 = '0;

        for (int i = 0; i < 3; i++)
            step4(1'b1, 64'($urandom()), 16'h0000);

        // Streaming Q8.8 groups, one per cycle, then zeros.
        step4(1'b0, pack4(16'h0400, 16'h0300, 16'h0200, 16'h0100), 16'h0A00);
        step4(1'b0, pack4(16'h0800, 16'h0700, 16'h0600, 16'h0500), 16'h1A00);
        step4(1'b0, pack4(16'h0C00, 16'h0B00, 16'h0A00, 16'h0900), 16'h2A00);
        step4(1'b0, pack4(16'h1000, 16'h0F00, 16'h0E00, 16'h0D00), 16'h3A00);
        step4(1'b0, pack4(16'h1400, 16'h1300, 16'h1200, 16'h1100), 16'h4A00);
        step4(1'b0, 64'h0, 16'h0000);
        step4(1'b0, 64'h0, 16'h0000);

        // Signed addends: -1.5 + 2.0 - 0.25 + 0.75 = 1.0
        step4(1'b0, pack4(16'hFE80, 16'h0200, 16'hFFC0, 16'h00C0), 16'h0100);

`ifdef GROUP_ADD_SATURATE_EN
        step4(1'b0, pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h7FFF);
        step4(1'b0, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 16'h8000);
`else
        step4(1'b0, pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'hFFFC);
        step4(1'b0, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 16'h0000);
`endif
        step4(1'b0, 64'h0, 16'h0000);

        // Mid-stream reset: the in-flight 10.0 must be discarded.
        step4(1'b0, pack4(16'h0400, 16'h0300, 16'h0200, 16'h0100), 16'h0A00);
        step4(1'b1, pack4(16'h0800, 16'h0700, 16'h0600, 16'h0500), 16'h0000);
        step4(1'b1, pack4(16'h0800, 16'h0700, 16'h0600, 16'h0500), 16'h0000);
        step4(1'b0, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100), 16'h0400);

        // Odd group sizes: {1,2,3} -> 6.0 and {5} -> 5.0
        step(1'b0, pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400), 16'h0A00,
             48'h0300_0200_0100, 16'h0600, 16'h0500, 16'h0500);
        step4(1'b0, 64'h0, 16'h0000);

        for (int i = 0; i < 24; i++)
            step_rand();

        step4(1'b0, 64'h0, 16'h0000);
        step4(1'b0, 64'h0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/group_add.md
GROUP_ADD -- requirements
Module: group_add

Interface
REQ-001 SHALL have parameter GROUP_NB, default 4: number of addends per group; legal range 1..64.
REQ-002 SHALL have parameter NUM_WIDTH, default 16: width of each addend and of the sum; legal range 2..64.
REQ-003 SHALL provide ports: clk  in  1  rising-edge clock, the only clock.
REQ-004 SHALL provide ports: rst  in  1  synchronous, active-high reset.
REQ-005 SHALL provide ports: up_data  in  NUM_WIDTH*GROUP_NB  packed addends; element i at bits [i*NUM_WIDTH +: NUM_WIDTH].
REQ-006 SHALL provide ports: dn_data  out  NUM_WIDTH  registered sum of one group.
REQ-007 SHALL treat every addend and dn_data as signed two's complement; fixed-point position is transparent because all addends share one format.

Function
REQ-008 SHALL accept a new group on every clk edge: no handshake, no stall, no valid signal.
REQ-009 SHALL compute dn_data = sum of the GROUP_NB elements of up_data, as a pipelined binary adder tree.
REQ-010 SHALL register each tree level, giving latency L = ceil(log2(GROUP_NB)) cycles, or 1 cycle when GROUP_NB = 1.
REQ-011 SHALL pass an odd leftover operand at any level through a register to the next level, so latency is uniform.
REQ-012 SHALL sign-extend by one bit at each level, so no intermediate overflow occurs; the final level is NUM_WIDTH+L bits.
REQ-013 SHALL, without the REQ-020 macro, truncate the final sum to its low NUM_WIDTH bits (modular wrap-around).
REQ-014 SHALL keep throughput at one result per cycle: a group sampled at edge n appears on dn_data after edge n+L-1 and is stable for one full cycle.
REQ-015 SHALL keep dn_data a pure register output, with no combinational path from up_data.

Reset
REQ-016 SHALL, when rst is high at a rising clk edge, clear every pipeline register, so dn_data = 0 after that edge.
REQ-017 SHALL, while rst is held, keep dn_data at 0 and discard any data in flight.
REQ-018 SHALL, for groups presented on the first edge after rst deasserts and later, produce correct sums L cycles later, with 0 output in the interim.
REQ-019 SHALL, when rst is asserted mid-stream, clear all in-flight partial sums with no residual output.

Configuration
REQ-020 SHALL, when macro GROUP_ADD_SATURATE_EN is defined, clamp the final sum to [-(2^(NUM_WIDTH-1)), 2^(NUM_WIDTH-1)-1] instead of wrapping.
REQ-021 SHALL, when GROUP_ADD_SATURATE_EN is undefined, wrap per REQ-013; the macro SHALL NOT change latency or ports.

Verification (GROUP_NB=4, NUM_WIDTH=16, Q8.8 values, L=2)
REQ-022 SHALL verify streaming: inputs {4,3,2,1}, {8,7,6,5}, {12,11,10,9}, {16,15,14,13}, {20,19,18,17} on consecutive cycles -> dn_data 10.0 (0x0A00), 26.0 (0x1A00), 42.0 (0x2A00), 58.0 (0x3A00), 74.0 (0x4A00) on consecutive cycles, each 2 cycles after its input; then 0 two cycles after input returns to 0.
REQ-023 SHALL verify signed addends: {-1.5, 2.0, -0.25, 0.75} -> dn_data 1.0 (0x0100).
REQ-024 SHALL verify overflow: four 0x7FFF addends -> dn_data 0xFFFC without the macro, 0x7FFF with it; four 0x8000 addends -> 0x0000 without, 0x8000 with.
REQ-025 SHALL verify reset: rst asserted one cycle after {4,3,2,1} is applied -> dn_data 0 on every cycle while rst is high, and the in-flight sum of 10.0 never appears.
REQ-026 SHALL verify odd group size: GROUP_NB=3 with {1,2,3} -> dn_data 6.0 (0x0600) after 2 cycles; GROUP_NB=1 with {5} -> 5.0 after 1 cycle.
